btb_predictor: RTL and testbench
================================

Name: btb_predictor

Overview:
- Parametrised branch target buffer with per-entry saturating direction counters, sitting beside the fetch stage of the RV32I pipeline.
- Produces a registered prediction for the fetched PC: hit, taken, target, and counter state. The counter state is carried down the pipe as the control word's btb_flag.
- Trained from the execute stage on branch/jump resolution.
- Generalises the fixed 2-bit btb_flag scheme to configurable depth, address width and counter width, and adds global flush.

Parameters:
- ENTRIES, 16, number of direct-mapped entries; power of two, >= 2.
- ADDR_W, 32, PC width in bits.
- CTR_W, 2, saturating counter width; btb_flag width equals CTR_W.
- Derived (localparam): IDX_W = log2(ENTRIES); TAG_W = ADDR_W - IDX_W - 2.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- fetch_valid  in  1  fetch PC is valid this cycle
- fetch_pc  in  ADDR_W  PC being fetched
- stall  in  1  hold prediction registers (IF/ID stall)
- pred_hit  out  1  registered: entry valid and tag match
- pred_taken  out  1  registered: pred_hit AND counter MSB
- pred_target  out  ADDR_W  registered target; 0 on miss
- pred_flag  out  CTR_W  registered counter value; 0 on miss
- upd_valid  in  1  execute-stage resolution valid
- upd_pc  in  ADDR_W  PC of the resolved branch
- upd_taken  in  1  actual direction
- upd_target  in  ADDR_W  actual target; used only when upd_taken=1
- flush_all  in  1  invalidate every entry

Behaviour:
- Reset (asynchronous, immediate):
  - All valid bits cleared; counters set to weakly-not-taken (MSB=0, remaining bits 1; 2'b01 for CTR_W=2).
  - All four pred_* outputs = 0.
  - Tags and targets need not be reset.
- Address decode: index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]. pc[1:0] is ignored.
- Lookup (1-cycle latency):
  - At an edge with stall=0, prediction registers load the result for fetch_pc.
  - If fetch_valid=0, they load all-zero.
  - stall=1 holds all pred_* unchanged, regardless of fetch_pc.
- Lookup reads pre-edge array state (read-before-write). An update at the same edge is not visible until the next lookup.
- Update (at edge with upd_valid=1):
  - Hit, taken: counter increments, saturating at all-ones; target overwritten with upd_target.
  - Hit, not taken: counter decrements, saturating at 0; target retained.
  - Miss, taken: allocate/replace the entry — valid=1, tag written, target=upd_target, counter=weakly-taken (MSB=1, rest 0; 2'b10 for CTR_W=2).
  - Miss, not taken: no change, no allocation.
- Aliasing: a different tag at the same index replaces the entry on a taken miss. The prior occupant then misses.
- flush_all: at the edge, all valid bits cleared and counters reset to weakly-not-taken.
  - Flush has priority over a simultaneous update; the update is discarded.
  - With stall=0 at the flush edge, the prediction registers load miss (zeros) regardless of lookup result.
- Reset mid-operation: takes effect without waiting for clk; state resumes from reset values on the first edge after deassertion.
- No X propagation: pred_target and pred_flag are forced to 0 whenever pred_hit=0.

Decomposition:
- Shared package btb_types holds:
  - struct btb_update_t: valid, pc, taken, target;
  - struct btb_pred_t: hit, taken, target, flag;
  - counter reset/allocate constants as functions of CTR_W.
- Sub-module sat_counter_next: combinational next-value of a CTR_W saturating counter given inc/dec. It is instantiated once on the update path.
- Arrays are flops, not SRAM macros; flush must clear valid bits in one cycle.

Test Plan (defaults: ENTRIES=16, CTR_W=2; 0x100 and 0x140 share index 0):
1. Reset, then lookup 0x100, fetch_valid=1 -> next cycle pred_hit=0, pred_taken=0, pred_target=0, pred_flag=0.
2. Update 0x100 taken target 0x200, then lookup 0x100 -> pred_hit=1, pred_flag=2'b10, pred_taken=1, pred_target=0x200.
3. Counter saturation: three not-taken updates to 0x100 -> flag 01, 00, 00, taken=0. Then four taken updates -> flag 01, 10, 11, 11; target stays 0x200 unless upd_target changes.
4. Alias: taken update 0x140 target 0x300 -> lookup 0x140 hit with target 0x300; lookup 0x100 -> pred_hit=0.
5. Same-edge lookup and update: lookup 0x100 (miss) coincident with taken update 0x100 -> that prediction is a miss, the following lookup hits. flush_all plus update 0x100 at the same edge -> subsequent lookup 0x100 misses.
6. Stall and reset: hit on 0x100 captured, then stall=1 for 3 cycles while fetch_pc=0x104 -> outputs hold 0x200/10. Assert rst between edges -> all pred_* = 0 immediately. Lookup 0x100 after reset release -> miss.

Source files
------------

// File: rtl/btb_predictor_pkg.sv
// Shared types and counter constants for the branch target buffer.
// Structs are sized for the default RV32I build; counter constants scale with CTR_W.
package btb_types;

  localparam int unsigned BTB_ADDR_W = 32;
  localparam int unsigned BTB_CTR_W  = 2;

  typedef struct packed {
    logic                  valid;
    logic [BTB_ADDR_W-1:0] pc;
    logic                  taken;
    logic [BTB_ADDR_W-1:0] target;
  } btb_update_t;

  typedef struct packed {
    logic                  hit;
    logic                  taken;
    logic [BTB_ADDR_W-1:0] target;
    logic [BTB_CTR_W-1:0]  flag;
  } btb_pred_t;

  // Weakly-not-taken: MSB clear, all lower bits set.
  function automatic int unsigned ctr_weak_nt(input int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  // Weakly-taken: MSB set, all lower bits clear.
  function automatic int unsigned ctr_weak_t(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/btb_predictor_if.sv
// Fetch/lookup, prediction and execute-stage training signals of the BTB.
// master = pipeline side, slave = predictor side.
interface btb_predictor_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CTR_W  = 2
);

  logic              fetch_valid;
  logic [ADDR_W-1:0] fetch_pc;
  logic              stall;
  logic              pred_hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic [CTR_W-1:0]  pred_flag;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              flush_all;

  modport master (
    output fetch_valid, fetch_pc, stall,
    output upd_valid, upd_pc, upd_taken, upd_target, flush_all,
    input  pred_hit, pred_taken, pred_target, pred_flag
  );

  modport slave (
    input  fetch_valid, fetch_pc, stall,
    input  upd_valid, upd_pc, upd_taken, upd_target, flush_all,
    output pred_hit, pred_taken, pred_target, pred_flag
  );

endinterface

// File: rtl/btb_predictor_sat_counter_next.sv
// Next value of a CTR_W-bit saturating counter; inc wins if both are set.
module sat_counter_next #(
  parameter int unsigned CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr,
  input  logic             inc,
  input  logic             dec,
  output logic [CTR_W-1:0] nxt
);

  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  always_comb begin
    // NOTE: default assignment first so every path drives nxt and no latch is inferred.
    nxt = ctr;
    if (inc) begin
      if (ctr != CTR_MAX) nxt = ctr + CTR_W'(1);
    end else if (dec) begin
      if (ctr != '0) nxt = ctr - CTR_W'(1);
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
// One-cycle registered lookup beside fetch; trained from execute; global flush.
module btb_predictor
  import btb_types::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned CTR_W   = 2
) (
  input logic            clk,
  input logic            rst,
  btb_predictor_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(ctr_weak_nt(CTR_W));
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(ctr_weak_t(CTR_W));

  logic [ENTRIES-1:0] valid_q;
  logic [CTR_W-1:0]   ctr_q [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [ADDR_W-1:0]  tgt_q [ENTRIES];

  // Byte offset within a word never participates in lookup or training.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{bus.fetch_pc[1:0], bus.upd_pc[1:0]};

  // Lookup path: reads the array as it stands before this edge.
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  assign f_idx = bus.fetch_pc[IDX_W+1:2];
  assign f_tag = bus.fetch_pc[ADDR_W-1:IDX_W+2];
  assign f_hit = bus.fetch_valid && valid_q[f_idx] && (tag_q[f_idx] == f_tag);

  // Update path.
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic [CTR_W-1:0] u_ctr_nxt;

  assign u_idx = bus.upd_pc[IDX_W+1:2];
  assign u_tag = bus.upd_pc[ADDR_W-1:IDX_W+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  sat_counter_next #(.CTR_W(CTR_W)) u_sat (
    .ctr (ctr_q[u_idx]),
    .inc (bus.upd_taken),
    .dec (!bus.upd_taken),
    .nxt (u_ctr_nxt)
  );

  // Valid bits and counters: reset and flushed in a single cycle.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) ctr_q[i] <= CTR_WNT;
    end else if (bus.flush_all) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) ctr_q[i] <= CTR_WNT;
    end else if (bus.upd_valid) begin
      if (u_hit) begin
        ctr_q[u_idx] <= u_ctr_nxt;
      end else if (bus.upd_taken) begin
        valid_q[u_idx] <= 1'b1;
        ctr_q[u_idx]   <= CTR_WT;
      end
    end
  end

  // NOTE: tags and targets carry no reset; they are qualified by valid_q, so clearing them buys nothing.
  always_ff @(posedge clk) begin
    if (!bus.flush_all && bus.upd_valid && bus.upd_taken) begin
      tag_q[u_idx] <= u_tag;
      tgt_q[u_idx] <= bus.upd_target;
    end
  end

  // Prediction registers; a flush edge forces a miss so stale entries never leak out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.pred_hit    <= 1'b0;
      bus.pred_taken  <= 1'b0;
      bus.pred_target <= '0;
      bus.pred_flag   <= '0;
    end else if (!bus.stall) begin
      if (f_hit && !bus.flush_all) begin
        bus.pred_hit    <= 1'b1;
        bus.pred_taken  <= ctr_q[f_idx][CTR_W-1];
        bus.pred_target <= tgt_q[f_idx];
        bus.pred_flag   <= ctr_q[f_idx];
      end else begin
        bus.pred_hit    <= 1'b0;
        bus.pred_taken  <= 1'b0;
        bus.pred_target <= '0;
        bus.pred_flag   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor (ENTRIES=16, ADDR_W=32, CTR_W=2).
// 0x100 and 0x140 share index 0 with tags 4 and 5.
module tb_btb_predictor;
  import btb_types::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  btb_predictor_if #(.ADDR_W(32), .CTR_W(2)) bus ();

  btb_predictor #(.ENTRIES(16), .ADDR_W(32), .CTR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic check_pred(input string tag, input btb_pred_t exp);
    check({tag, ".hit"},    32'(bus.pred_hit),    32'(exp.hit));
    check({tag, ".taken"},  32'(bus.pred_taken),  32'(exp.taken));
    check({tag, ".target"}, bus.pred_target,      exp.target);
    check({tag, ".flag"},   32'(bus.pred_flag),   32'(exp.flag));
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fetch(input logic v, input logic [31:0] pc);
    bus.fetch_valid = v;
    bus.fetch_pc    = pc;
  endtask

  task automatic set_upd(input btb_update_t u);
    bus.upd_valid  = u.valid;
    bus.upd_pc     = u.pc;
    bus.upd_taken  = u.taken;
    bus.upd_target = u.target;
  endtask

  // Train at one edge, then look the same PC up at the next.
  task automatic train_then_look(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    set_upd('{valid: 1'b1, pc: pc, taken: tk, target: tgt});
    set_fetch(1'b0, 32'h0);
    tick();
    set_upd('0);
    set_fetch(1'b1, pc);
    tick();
  endtask

  localparam btb_pred_t MISS = '0;

  initial begin
    bus.stall     = 1'b0;
    bus.flush_all = 1'b0;
    set_fetch(1'b0, 32'h0);
    set_upd('0);

    // 1. Reset state and a lookup into an empty buffer.
    #12;
    check_pred("reset", MISS);
    rst = 1'b0;
    set_fetch(1'b1, 32'h100);
    tick();
    check_pred("empty_lookup", MISS);

    // 2. Taken allocation, then hit with weakly-taken counter.
    train_then_look(32'h100, 1'b1, 32'h200);
    check_pred("alloc", '{hit: 1'b1, taken: 1'b1, target: 32'h200, flag: 2'b10});

    // 3. Counter walks down to 0 and saturates, then up to 3 and saturates.
    train_then_look(32'h100, 1'b0, 32'h0);
    check_pred("nt1", '{hit: 1'b1, taken: 1'b0, target: 32'h200, flag: 2'b01});
    train_then_look(32'h100, 1'b0, 32'h0);
    check_pred("nt2", '{hit: 1'b1, taken: 1'b0, target: 32'h200, flag: 2'b00});
    train_then_look(32'h100, 1'b0, 32'h0);
    check_pred("nt3_sat", '{hit: 1'b1, taken: 1'b0, target: 32'h200, flag: 2'b00});
    train_then_look(32'h100, 1'b1, 32'h200);
    check_pred("t1", '{hit: 1'b1, taken: 1'b0, target: 32'h200, flag: 2'b01});
    train_then_look(32'h100, 1'b1, 32'h200);
    check_pred("t2", '{hit: 1'b1, taken: 1'b1, target: 32'h200, flag: 2'b10});
    train_then_look(32'h100, 1'b1, 32'h200);
    check_pred("t3", '{hit: 1'b1, taken: 1'b1, target: 32'h200, flag: 2'b11});
    train_then_look(32'h100, 1'b1, 32'h240);
    check_pred("t4_sat_newtgt", '{hit: 1'b1, taken: 1'b1, target: 32'h240, flag: 2'b11});

    // 4. Alias at index 0 evicts 0x100.
    train_then_look(32'h140, 1'b1, 32'h300);
    check_pred("alias_hit", '{hit: 1'b1, taken: 1'b1, target: 32'h300, flag: 2'b10});
    set_fetch(1'b1, 32'h100);
    tick();
    check_pred("alias_evicted", MISS);

    // 5. Same-edge lookup and update: lookup sees the old contents.
    set_upd('{valid: 1'b1, pc: 32'h100, taken: 1'b1, target: 32'h200});
    set_fetch(1'b1, 32'h100);
    tick();
    check_pred("same_edge_miss", MISS);
    set_upd('0);
    tick();
    check_pred("same_edge_next", '{hit: 1'b1, taken: 1'b1, target: 32'h200, flag: 2'b10});
    // Flush beats a coincident update and forces the prediction to miss.
    bus.flush_all = 1'b1;
    set_upd('{valid: 1'b1, pc: 32'h100, taken: 1'b1, target: 32'h280});
    tick();
    check_pred("flush_edge", MISS);
    bus.flush_all = 1'b0;
    set_upd('0);
    tick();
    check_pred("after_flush", MISS);

    // 6. Stall holds the prediction regardless of fetch_pc.
    train_then_look(32'h100, 1'b1, 32'h200);
    check_pred("pre_stall", '{hit: 1'b1, taken: 1'b1, target: 32'h200, flag: 2'b10});
    bus.stall = 1'b1;
    set_fetch(1'b1, 32'h104);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_pred($sformatf("stall%0d", i), '{hit: 1'b1, taken: 1'b1, target: 32'h200, flag: 2'b10});
    end
    // Reset between edges clears the outputs without a clock.
    #2 rst = 1'b1;
    #1 check_pred("async_reset", MISS);
    #2 rst = 1'b0;
    bus.stall = 1'b0;
    set_fetch(1'b1, 32'h100);
    tick();
    check_pred("post_reset", MISS);

    // fetch_valid=0 loads zeros even when the PC would hit.
    train_then_look(32'h100, 1'b1, 32'h200);
    check_pred("realloc", '{hit: 1'b1, taken: 1'b1, target: 32'h200, flag: 2'b10});
    set_fetch(1'b0, 32'h100);
    tick();
    check_pred("fetch_invalid", MISS);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
